// File: rtl/pc_pkg.sv
// Shared definitions for the password checker and the character counters
// that feed it.
package pc_pkg;

  localparam int CHAR_W = 8;

  // Printable ASCII window swept by the upstream character counters.
  localparam logic [CHAR_W-1:0] ASCII_FIRST = 8'h20;
  localparam logic [CHAR_W-1:0] ASCII_LAST  = 8'h7E;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

endpackage

// File: rtl/pc_target_reg.sv
// Byte-addressable N_CHARS-character target password store with a
// full-width equality compare against a candidate word.
module pc_target_reg
  import pc_pkg::*;
#(
  parameter int N_CHARS = 4,
  parameter int IDX_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [CHAR_W-1:0]          wr_char,
  input  logic [CHAR_W*N_CHARS-1:0]  word,
  output logic                       eq
);

  logic [N_CHARS-1:0][CHAR_W-1:0] target;

  // Indices with no matching byte lane simply write nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else if (we) begin
      for (int i = 0; i < N_CHARS; i++) begin
        if (idx == IDX_W'(i)) target[i] <= wr_char;
      end
    end
  end

  assign eq = (word == target);

endmodule

// File: rtl/password_checker.sv
// Compares streamed candidate words against a stored target and reports a
// match or exhaustion, throttling the generator through cand_ready.
module password_checker
  import pc_pkg::*;
#(
  parameter int N_CHARS = 4,
  parameter int CNT_W   = 32,
  localparam int IDX_W  = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tgt_we,
  input  logic [IDX_W-1:0]           tgt_idx,
  input  logic [CHAR_W-1:0]          tgt_char,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       cand_valid,
  input  logic [CHAR_W*N_CHARS-1:0]  cand,
  input  logic                       cand_last,
  output logic                       cand_ready,
  output logic                       busy,
  output logic                       found,
  output logic                       done,
  output logic [CHAR_W*N_CHARS-1:0]  match_word,
  output logic [CNT_W-1:0]           attempts
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                      state;
  logic [CHAR_W*N_CHARS-1:0]   cand_p1;
  logic                        last_p1;
  logic                        vld_p1;
  logic                        eq;
  logic                        hit;
  logic                        accept;

  pc_target_reg #(.N_CHARS(N_CHARS), .IDX_W(IDX_W)) u_target (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (tgt_we && (state == IDLE)),
    .idx     (tgt_idx),
    .wr_char (tgt_char),
    .word    (cand_p1),
    .eq      (eq)
  );

  assign hit        = vld_p1 && eq;
  // Stall as soon as the word in stage 1 will end the search, so nothing
  // accepted is ever dropped.
  assign cand_ready = (state == SEARCH) && !(vld_p1 && (eq || last_p1));
  assign accept     = cand_valid && cand_ready;
  assign busy       = (state == SEARCH);
  assign found      = (state == FOUND);
  assign done       = (state == FOUND) || (state == EXHAUSTED);

  // Stage 1 boundary: candidate data captured on each handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      cand_p1 <= cand;
      last_p1 <= cand_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vld_p1     <= 1'b0;
      attempts   <= '0;
      match_word <= '0;
    end else if (abort) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          if (start) begin
            state      <= SEARCH;
            attempts   <= '0;
            match_word <= '0;
          end
        end
        SEARCH: begin
          vld_p1 <= accept;
          if (vld_p1) attempts <= sat_inc(attempts);
          if (hit) begin
            state      <= FOUND;
            match_word <= cand_p1;
          end else if (vld_p1 && last_p1) begin
            state <= EXHAUSTED;
          end
        end
        default: vld_p1 <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_password_checker.sv
// Directed self-checking bench for password_checker with two-character words.
module tb_password_checker;

  localparam int N_CHARS = 2;
  localparam int CNT_W   = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tgt_we;
  logic [0:0]  tgt_idx;
  logic [7:0]  tgt_char;
  logic        start;
  logic        abort;
  logic        cand_valid;
  logic [15:0] cand;
  logic        cand_last;
  logic        cand_ready;
  logic        busy;
  logic        found;
  logic        done;
  logic [15:0] match_word;
  logic [31:0] attempts;

  int n_cmp = 0;
  int n_err = 0;

  password_checker #(.N_CHARS(N_CHARS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_we     (tgt_we),
    .tgt_idx    (tgt_idx),
    .tgt_char   (tgt_char),
    .start      (start),
    .abort      (abort),
    .cand_valid (cand_valid),
    .cand       (cand),
    .cand_last  (cand_last),
    .cand_ready (cand_ready),
    .busy       (busy),
    .found      (found),
    .done       (done),
    .match_word (match_word),
    .attempts   (attempts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tgt(input logic [0:0] idx, input logic [7:0] ch);
    tgt_we = 1'b1; tgt_idx = idx; tgt_char = ch;
    tick();
    tgt_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Present one word and hold it until accepted, bounded at 20 cycles.
  task automatic send(input string tag, input logic [15:0] w, input logic last);
    logic ok;
    ok = 1'b0;
    cand_valid = 1'b1; cand = w; cand_last = last;
    for (int i = 0; i < 20; i++) begin
      if (cand_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    cand_valid = 1'b0; cand_last = 1'b0;
    if (!ok) check(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int gaps [5];
    logic [15:0] words [5];
    gaps  = '{0, 1, 2, 3, 0};
    words = '{16'h4141, 16'h4242, 16'h4343, 16'h4444, 16'h4545};

    rst_n = 1'b0; tgt_we = 1'b0; tgt_idx = '0; tgt_char = '0;
    start = 1'b0; abort = 1'b0; cand_valid = 1'b0; cand = '0; cand_last = 1'b0;
    #3;
    check("rst_ready",    64'(cand_ready), 64'd0);
    check("rst_busy",     64'(busy),       64'd0);
    check("rst_done",     64'(done),       64'd0);
    check("rst_attempts", 64'(attempts),   64'd0);
    check("rst_match",    64'(match_word), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Match on the second of two back-to-back words
    write_tgt(1'b0, 8'h41);
    write_tgt(1'b1, 8'h42);
    do_start();
    check("t1_busy",  64'(busy),       64'd1);
    check("t1_ready", 64'(cand_ready), 64'd1);
    cand_valid = 1'b1; cand = 16'h4141;
    tick();
    check("t1_ready2", 64'(cand_ready), 64'd1);
    cand = 16'h4241;
    tick();
    cand_valid = 1'b0;
    check("t1_stall",     64'(cand_ready), 64'd0);
    check("t1_found_lat", 64'(found),      64'd0);
    tick();
    check("t1_found",    64'(found),      64'd1);
    check("t1_done",     64'(done),       64'd1);
    check("t1_busy_off", 64'(busy),       64'd0);
    check("t1_match",    64'(match_word), 64'h4241);
    check("t1_attempts", 64'(attempts),   64'd2);

    // Abort retains results; exhaustion without a match
    do_abort();
    check("t2_idle_found", 64'(found),      64'd0);
    check("t2_keep_att",   64'(attempts),   64'd2);
    check("t2_keep_match", 64'(match_word), 64'h4241);
    write_tgt(1'b0, 8'h7A);
    write_tgt(1'b1, 8'h7A);
    do_start();
    check("t2_att_clr", 64'(attempts), 64'd0);
    send("t2_acc0", 16'h4141, 1'b0);
    send("t2_acc1", 16'h4142, 1'b0);
    send("t2_acc2", 16'h4143, 1'b1);
    check("t2_stall", 64'(cand_ready), 64'd0);
    cand_valid = 1'b1; cand = 16'h4144;
    tick();
    check("t2_done",     64'(done),     64'd1);
    check("t2_found",    64'(found),    64'd0);
    check("t2_state",    64'(dut.state), 64'd3);
    check("t2_attempts", 64'(attempts), 64'd3);
    tick(); tick();
    check("t2_no_accept", 64'(cand_ready), 64'd0);
    check("t2_att_hold",  64'(attempts),   64'd3);
    cand_valid = 1'b0;

    // Match on the last candidate takes priority over exhaustion
    do_abort();
    write_tgt(1'b0, 8'h43);
    write_tgt(1'b1, 8'h43);
    do_start();
    send("t3_acc0", 16'h4141, 1'b0);
    send("t3_acc1", 16'h4142, 1'b0);
    send("t3_acc2", 16'h4343, 1'b1);
    tick();
    check("t3_found",    64'(found),      64'd1);
    check("t3_state",    64'(dut.state),  64'd2);
    check("t3_match",    64'(match_word), 64'h4343);
    check("t3_attempts", 64'(attempts),   64'd3);

    // Valid gaps do not count as attempts
    do_abort();
    write_tgt(1'b0, 8'h45);
    write_tgt(1'b1, 8'h45);
    do_start();
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < gaps[i]; g++) tick();
      if (i == 3) check("t4_gap_att", 64'(attempts), 64'd3);
      send("t4_acc", words[i], 1'b0);
    end
    tick();
    check("t4_found",    64'(found),      64'd1);
    check("t4_match",    64'(match_word), 64'h4545);
    check("t4_attempts", 64'(attempts),   64'd5);

    // Abort mid-search, then a fresh search
    do_abort();
    write_tgt(1'b0, 8'h5A);
    write_tgt(1'b1, 8'h5A);
    do_start();
    send("t5_acc0", 16'h4141, 1'b0);
    send("t5_acc1", 16'h4242, 1'b0);
    send("t5_acc2", 16'h4343, 1'b0);
    tick();
    do_abort();
    check("t5_busy",     64'(busy),       64'd0);
    check("t5_ready",    64'(cand_ready), 64'd0);
    check("t5_attempts", 64'(attempts),   64'd3);
    do_start();
    check("t5_restart_att",  64'(attempts), 64'd0);
    check("t5_restart_busy", 64'(busy),     64'd1);
    send("t5_acc3", 16'h5A5A, 1'b0);
    tick();
    check("t5_found",    64'(found),    64'd1);
    check("t5_attempts", 64'(attempts), 64'd1);

    // Abort wins over a simultaneous start
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("t6_abort_start", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a search
    do_start();
    send("t7_acc0", 16'h4141, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t7_busy",     64'(busy),       64'd0);
    check("t7_ready",    64'(cand_ready), 64'd0);
    check("t7_attempts", 64'(attempts),   64'd0);
    check("t7_match",    64'(match_word), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    do_start();
    send("t7_acc1", 16'h0000, 1'b0);
    tick();
    check("t7_zero_found", 64'(found),    64'd1);
    check("t7_zero_att",   64'(attempts), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
